countone_seq: RTL and testbench
===============================

# countone_seq

Sequential population-count controller that time-shares a single 6-bit `countone` datapath (6-bit input, 3-bit ones count) to count the ones in a word of `6*CHUNKS` bits. It accepts a word through a valid/ready handshake and feeds it to `countone` one 6-bit chunk per cycle, least-significant chunk first. It accumulates the partial counts and presents the total through a second valid/ready handshake. It sits between a word producer and a result consumer wherever a wide ones count is needed without replicating `countone`.

## Interface
- `CHUNKS`, default 4: number of 6-bit chunks per word; legal range 1..16; word width W = 6*CHUNKS.
- `CW`, default 5: count width, equal to $clog2(6*CHUNKS+1); must be set consistently with `CHUNKS`.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  W  word to count; sampled only on an accept.
- `out_valid`  out  1  `out_count` holds a finished result.
- `out_ready`  in  1  consumer takes the result.
- `out_count`  out  CW  total number of ones in the accepted word.
- `busy`  out  1  high in the RUN state.

## Operation
- Contains exactly one `countone` instance. Its input is the low 6 bits of an internal W-bit shift register `sh`.
- FSM has three states: IDLE, RUN and DONE.
  - IDLE: `in_ready`=1. On accept (`in_valid`&&`in_ready`): `sh`<=`in_data`, `acc`<=0, `idx`<=0, next state RUN. Otherwise stay.
  - RUN: each cycle `acc`<=`acc`+zero-extended `countone` out, `sh`<=`sh`>>6, `idx`<=`idx`+1. When `idx`==CHUNKS-1, next state DONE; this last cycle still adds its chunk.
  - DONE: `out_valid`=1. `out_count` is driven directly from `acc`. When `out_ready`=1, next state IDLE. Otherwise hold.
- `in_ready` is 1 only in IDLE. `out_valid` is 1 only in DONE. `busy` is 1 only in RUN. All are decoded from registered state, with no combinational path from inputs.
- `in_valid` and `in_data` are ignored outside IDLE. `out_ready` is ignored outside DONE.
- Arithmetic: `acc` is CW bits wide and cannot overflow, since the maximum is 6*CHUNKS.
- `idx` is $clog2(CHUNKS) bits wide, minimum 1 bit. It resets to 0 on each accept and never wraps inside one word.
- `out_count` is stable for the whole time `out_valid` is high and backpressure is applied.

## Timing
- Reset values: state=IDLE, `acc`=0, `sh`=0, `idx`=0.
- Resulting outputs during/after reset: `in_ready`=1, `out_valid`=0, `busy`=0, `out_count`=0.
- Reset has priority over every other event. Asserting it mid-RUN or mid-DONE discards the word and the result, and returns to IDLE on the next edge.
- Latency: with the accept at edge T, RUN occupies edges T+1..T+CHUNKS. `out_valid` is first high after edge T+CHUNKS.
- Minimum period between accepts is CHUNKS+2 cycles: one cycle accept, CHUNKS cycles RUN, at least one cycle DONE. There is no overlap, and IDLE is revisited before the next accept.
- CHUNKS=1: RUN lasts one cycle; IDLE→RUN→DONE.
- A consumer holding `out_ready`=1 continuously gets DONE for exactly one cycle.
- `in_valid` may be high across the DONE→IDLE transition. The word is accepted on the first IDLE cycle.

## Test plan
- Reset, then CHUNKS=4, `in_data`={6'b000001,6'b111101,6'b000000,6'b111111}, `out_ready`=1 → `out_valid` rises 4 cycles after accept; `out_count`=12; `busy` high for exactly 4 cycles.
- `in_data`=24'hFFFFFF → `out_count`=24. `in_data`=24'h000000 → `out_count`=0. Back-to-back with `in_valid` held high → accepts exactly 6 cycles apart.
- Backpressure: `in_data`=24'h00003D, `out_ready`=0 for 5 cycles after `out_valid` → `out_count`=5 held constant, `in_ready`=0 throughout. A `in_valid` pulse with 24'hFFFFFF during DONE is ignored; the next result after re-accept follows the IDLE-sampled data only.
- Reset mid-operation: assert `reset` one cycle at the 2nd RUN cycle → next cycle IDLE, `out_valid`=0, `out_count`=0. A subsequent word 24'h000FFF yields 12, with no contamination from the aborted word.
- CHUNKS=1 instance, `in_data`=6'b111101 → `out_count`=5 one cycle after accept. CHUNKS=16 instance, all ones → `out_count`=96, with CW=7.

Source files
------------

// File: rtl/countone_seq.sv
// countone_seq: ones count of a 6*CHUNKS-bit word through one shared 6-bit countone,
// one chunk per cycle, least-significant chunk first, with valid/ready on both sides.
module countone (
  input  logic [5:0] i_d,
  output logic [2:0] o_n
);
  always_comb o_n = {2'b0, i_d[0]} + {2'b0, i_d[1]} + {2'b0, i_d[2]}
                  + {2'b0, i_d[3]} + {2'b0, i_d[4]} + {2'b0, i_d[5]};
endmodule

module countone_seq #(
  parameter int CHUNKS = 4,
  parameter int CW     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6*CHUNKS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_count,
  output logic                busy
);
  localparam int W  = 6 * CHUNKS;
  localparam int IW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        r_state;
  logic [W-1:0]  r_sh;
  logic [CW-1:0] r_acc;
  logic [IW-1:0] r_idx;
  logic [2:0]    w_cnt;
  countone u_countone (.i_d(r_sh[5:0]), .o_n(w_cnt));
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state == RUN;
  assign out_count = r_acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_sh    <= in_data;
          r_acc   <= '0;
          r_idx   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_acc <= r_acc + CW'(w_cnt);
          r_sh  <= r_sh >> 6;
          r_idx <= r_idx + 1'b1;
          if (r_idx == IW'(CHUNKS - 1)) r_state <= DONE;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_countone_seq.sv
// tb_countone_seq: directed checks of countone_seq at CHUNKS=4, 1 and 16.
module tb_countone_seq;
  logic clk = 0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [23:0] in_data;
  logic [4:0] out_count;
  logic v1, r1, ov1, or1, b1;
  logic [5:0] d1;
  logic [2:0] c1;
  logic v16, r16, ov16, or16, b16;
  logic [95:0] d16;
  logic [6:0] c16;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int acc_at[3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  countone_seq #(.CHUNKS(4), .CW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .busy(busy));
  countone_seq #(.CHUNKS(1), .CW(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_count(c1), .busy(b1));
  countone_seq #(.CHUNKS(16), .CW(7)) dut16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(r16), .in_data(d16),
    .out_valid(ov16), .out_ready(or16), .out_count(c16), .busy(b16));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask
  task automatic run_word(input logic [23:0] d, input int exp, input string tag);
    int k = 0, nb = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    chk({tag, ".rdy"}, in_ready, 1);
    in_valid = 1; in_data = d;
    @(negedge clk);
    in_valid = 0; in_data = '0;
    k = 0;
    while (!out_valid && k < 20) begin
      if (busy) nb++;
      @(negedge clk); k++;
    end
    chk({tag, ".lat"}, k, 4);
    chk({tag, ".busy"}, nb, 4);
    chk({tag, ".cnt"}, out_count, exp);
    if (out_ready) begin
      @(negedge clk);
      chk({tag, ".ov1cyc"}, out_valid, 0);
    end
  endtask
  initial begin
    reset = 1; in_valid = 0; in_data = '0; out_ready = 1;
    v1 = 0; d1 = '0; or1 = 1; v16 = 0; d16 = '0; or16 = 1;
    @(negedge clk); @(negedge clk);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.out_count", out_count, 0);
    chk("rst1.in_ready", r1, 1);
    reset = 0;
    @(negedge clk);
    run_word(24'h07D03F, 12, "mix");
    run_word(24'hFFFFFF, 24, "ones");
    run_word(24'h000000, 0, "zero");
    // back-to-back: in_valid held, accepts should land every 6 cycles
    in_valid = 1; in_data = 24'hFFFFFF;
    for (int i = 0, a = 0; i < 16; i++) begin
      if (in_ready && a < 3) begin acc_at[a] = cyc; a++; end
      if (out_valid) chk("b2b.cnt", out_count, 24);
      @(negedge clk);
    end
    chk("b2b.gap1", acc_at[1] - acc_at[0], 6);
    chk("b2b.gap2", acc_at[2] - acc_at[1], 6);
    in_valid = 0;
    for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
    // backpressure with a stray word offered during DONE
    out_ready = 0;
    run_word(24'h00003D, 5, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); in_data = (i == 2) ? 24'hFFFFFF : 24'h0;
      @(negedge clk);
      chk("bp.hold", out_count, 5);
      chk("bp.in_ready", in_ready, 0);
      chk("bp.ov", out_valid, 1);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("bp.idle", in_ready, 1);
    chk("bp.ov0", out_valid, 0);
    run_word(24'h000003, 2, "post");
    // reset during the second RUN cycle
    in_valid = 1; in_data = 24'hFFFFFF;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("abort.busy", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort.in_ready", in_ready, 1);
    chk("abort.ov", out_valid, 0);
    chk("abort.cnt", out_count, 0);
    chk("abort.busy0", busy, 0);
    run_word(24'h000FFF, 12, "after");
    // CHUNKS=1
    v1 = 1; d1 = 6'b111101;
    @(negedge clk);
    v1 = 0;
    chk("c1.busy", b1, 1);
    @(negedge clk);
    chk("c1.ov", ov1, 1);
    chk("c1.cnt", c1, 5);
    @(negedge clk);
    chk("c1.idle", r1, 1);
    // CHUNKS=16
    v16 = 1; d16 = '1;
    @(negedge clk);
    v16 = 0;
    for (int i = 0; i < 16; i++) begin
      chk("c16.busy", b16, 1);
      @(negedge clk);
    end
    chk("c16.ov", ov16, 1);
    chk("c16.cnt", c16, 96);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
